// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris engine and its command issuer:
// engine command codes and the issuer's sequencing states.
package tetris_pkg;

    typedef enum logic [2:0] {
        CTRL_NONE = 3'd0,
        HOLD      = 3'd1,
        ROTATE    = 3'd2,
        LEFT      = 3'd3,
        RIGHT     = 3'd4,
        DOWN      = 3'd5,
        BAR       = 3'd6,
        START     = 3'd7
    } ctrl_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_START1,
        ST_START2
    } issuer_state_e;

    localparam int NUM_BTN = 6;
    localparam int CTRL_W  = 3;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command queue with a first-word-fall-through head.
// Flush empties the queue and discards any push in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tetris_ctrl_issuer.sv
// Turns button edges, start and a gravity tick into queued engine commands,
// issuing each one as a single-cycle ctrl code when the engine is ready.
module tetris_ctrl_issuer
    import tetris_pkg::*;
#(
    parameter int unsigned DROP_PERIOD = 50_000_000,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_BTN-1:0]            btn,
    input  logic                          start,
    input  logic                          ready,
    output logic [CTRL_W-1:0]             ctrl,
    output logic [$clog2(FIFO_DEPTH):0]   q_count,
    output logic                          busy
);

    localparam int          NIN       = NUM_BTN + 1;
    localparam logic [31:0] GRAV_LAST = 32'(DROP_PERIOD - 32'd1);

    logic [NIN-1:0]     sync_q [SYNC_STAGES];
    logic [NIN-1:0]     prev_q;
    logic [NIN-1:0]     edge_w;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic               grav_pend_q, grav_pend_d;
    logic               start_pend_q, start_pend_d;
    logic [31:0]        grav_cnt_q, grav_cnt_d;
    logic               grav_wrap;
    issuer_state_e      state_q, state_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [NIN-1:0]     src_w;
    logic [NIN-1:0]     push_mask;
    logic [CTRL_W-1:0]  push_code;
    logic               push_en;
    logic               pop_w;
    logic               flush_w;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CTRL_W-1:0]  fifo_head;

    // Bit NUM_BTN of the chain carries start alongside the buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= {start, btn};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_w    = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign grav_wrap = (grav_cnt_q == GRAV_LAST);
    assign src_w     = {grav_pend_q, pend_q};

    // Scan high to low so the lowest set index (highest priority) wins.
    always_comb begin
        push_mask = '0;
        push_code = CTRL_NONE;
        for (int i = NIN - 1; i >= 0; i--) begin
            if (src_w[i]) begin
                push_mask    = '0;
                push_mask[i] = 1'b1;
                push_code    = (i == NUM_BTN) ? DOWN : CTRL_W'(i + 1);
            end
        end
    end

    assign push_en = (|src_w) && !fifo_full && !flush_w;

    always_comb begin
        if (flush_w) begin
            pend_d       = edge_w[NUM_BTN-1:0];
            grav_pend_d  = 1'b0;
            start_pend_d = edge_w[NUM_BTN];
            grav_cnt_d   = '0;
        end else begin
            pend_d       = (pend_q & ~(push_en ? push_mask[NUM_BTN-1:0] : '0))
                           | edge_w[NUM_BTN-1:0];
            grav_pend_d  = (grav_pend_q & ~(push_en & push_mask[NUM_BTN])) | grav_wrap;
            start_pend_d = start_pend_q | edge_w[NUM_BTN];
            grav_cnt_d   = grav_wrap ? '0 : grav_cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = CTRL_NONE;
        flush_w = 1'b0;
        pop_w   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_pend_q) begin
                    flush_w = 1'b1;
                    ctrl_d  = START;
                    state_d = ST_START1;
                end else if (ready && !fifo_empty) begin
                    pop_w   = 1'b1;
                    ctrl_d  = fifo_head;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE:  state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            ST_START1: begin
                ctrl_d  = START;
                state_d = ST_START2;
            end
            ST_START2: state_d = ST_SETTLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ctrl_q       <= CTRL_NONE;
            pend_q       <= '0;
            grav_pend_q  <= 1'b0;
            start_pend_q <= 1'b0;
            grav_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            pend_q       <= pend_d;
            grav_pend_q  <= grav_pend_d;
            start_pend_q <= start_pend_d;
            grav_cnt_q   <= grav_cnt_d;
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CTRL_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_en),
        .push_data_i (push_code),
        .pop_i       (pop_w),
        .flush_i     (flush_w),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head),
        .count_o     (q_count)
    );

    assign ctrl = ctrl_q;
    assign busy = (state_q != ST_IDLE);

endmodule
